// File: rtl/map_loader_if.sv
// -----------------------------------------------------------------------------
// map_loader_if
// Purpose : Valid/ready cell-write port between the puzzle map loader and the
//           game board storage.
// Signals :
//   cell_valid     loader -> board  write request valid
//   cell_ready     board  -> loader board accepts the write this cycle
//   cell_addr      loader -> board  cell index, row*9 + col
//   cell_value     loader -> board  digit when shown, 0 when hidden
//   cell_solution  loader -> board  solution digit, always
//   cell_given     loader -> board  visibility bit (1 = shown / given)
// Modports: master (loader side), slave (board side).
// -----------------------------------------------------------------------------
interface map_loader_if #(
   parameter int AW = 7,
   parameter int DW = 4
);
   logic          cell_valid;
   logic          cell_ready;
   logic [AW-1:0] cell_addr;
   logic [DW-1:0] cell_value;
   logic [DW-1:0] cell_solution;
   logic          cell_given;

   modport master (
      output cell_valid, cell_addr, cell_value, cell_solution, cell_given,
      input  cell_ready
   );

   modport slave (
      input  cell_valid, cell_addr, cell_value, cell_solution, cell_given,
      output cell_ready
   );
endinterface

// File: rtl/map_loader.sv
// -----------------------------------------------------------------------------
// map_loader
// Purpose : Reads one puzzle (solution digits + visibility mask) out of the
//           packed puzzle-map bank and streams it cell by cell, addresses
//           0..CELLS-1, to the board storage over a valid/ready write port.
//           Hidden cells carry value 0; shown cells carry their digit and are
//           flagged given.
// Ports   :
//   clk            clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   start_i        load request, sampled only while idle
//   puzzle_sel_i   puzzle index, 0..NUM_MAPS-1
//   maps_i         packed solution digits, puzzle 0 cell 0 at the MSBs
//   visibilities_i packed visibility mask, 1 = shown, puzzle 0 cell 0 at MSB
//   busy_o         high from accepted start until the done cycle
//   done_o         one-cycle pulse after the last cell was accepted
//   sel_err_o      one-cycle pulse for a start with an out-of-range index
//   map_err_o      sticky row-check failure (0 unless MAP_LOADER_CHECK_EN)
//   cell_if        cell write port (master side)
// Build option:
//   MAP_LOADER_CHECK_EN  when defined, every accepted row is checked to hold
//                        the digits 1..9 exactly once; failures set map_err_o.
// -----------------------------------------------------------------------------
module map_loader #(
   parameter int NUM_MAPS = 15,
   parameter int CELLS    = 81,
   parameter int DIGIT_W  = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start_i,
   input  logic [3:0]                         puzzle_sel_i,
   input  logic [NUM_MAPS*CELLS*DIGIT_W-1:0]  maps_i,
   input  logic [NUM_MAPS*CELLS-1:0]          visibilities_i,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               sel_err_o,
   output logic                               map_err_o,
   map_loader_if.master                       cell_if
);
   localparam int TOTAL = NUM_MAPS * CELLS;
   localparam int KW    = $clog2(TOTAL);
   localparam int AW    = $clog2(CELLS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIN} state_t;

   // Flat per-cell views of the bank so a cell is one array lookup.
   logic [DIGIT_W-1:0] digit_arr [TOTAL];
   logic               vis_arr   [TOTAL];

   for (genvar gi = 0; gi < TOTAL; gi++) begin : g_unpack
      assign digit_arr[gi] = maps_i[TOTAL*DIGIT_W-1-DIGIT_W*gi -: DIGIT_W];
      assign vis_arr[gi]   = visibilities_i[TOTAL-1-gi];
   end

   state_t             state_q, state_d;
   logic [3:0]         sel_q, sel_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               sel_err_q, sel_err_d;
   logic [DIGIT_W-1:0] sol_q, sol_d;
   logic [DIGIT_W-1:0] value_q, value_d;
   logic               given_q, given_d;
   logic [KW-1:0]      k_d;

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      sel_err_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (int'(puzzle_sel_i) < NUM_MAPS) begin
                  sel_d   = puzzle_sel_i;
                  addr_d  = '0;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  state_d = S_LOAD;
               end else begin
                  sel_err_d = 1'b1;
               end
            end
         end
         S_LOAD: begin
            // cell_valid is always high in LOAD, so ready alone means accept.
            if (cell_if.cell_ready) begin
               if (addr_q == LAST_ADDR) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_FIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Cell data registers follow the (next) address; with sel/addr held
      // during a stall they hold too, and no ready path reaches the outputs.
      k_d     = KW'(sel_d) * KW'(CELLS) + KW'(addr_d);
      sol_d   = sol_q;
      value_d = value_q;
      given_d = given_q;
      if (valid_d) begin
         sol_d   = digit_arr[k_d];
         given_d = vis_arr[k_d];
         value_d = vis_arr[k_d] ? digit_arr[k_d] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sel_err_q <= 1'b0;
         sol_q     <= '0;
         value_q   <= '0;
         given_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sel_err_q <= sel_err_d;
         sol_q     <= sol_d;
         value_q   <= value_d;
         given_q   <= given_d;
      end
   end

   assign busy_o                = busy_q;
   assign done_o                = done_q;
   assign sel_err_o             = sel_err_q;
   assign cell_if.cell_valid    = valid_q;
   assign cell_if.cell_addr     = addr_q;
   assign cell_if.cell_value    = value_q;
   assign cell_if.cell_solution = sol_q;
   assign cell_if.cell_given    = given_q;

`ifdef MAP_LOADER_CHECK_EN
   logic       accept, start_acc;
   logic [8:0] mask_q, mask_d, mask_new;
   logic [3:0] col_q, col_d;
   logic       err_q, err_d;

   assign accept    = (state_q == S_LOAD) && cell_if.cell_ready;
   assign start_acc = (state_q == S_IDLE) && start_i && (int'(puzzle_sel_i) < NUM_MAPS);

   // The digit being accepted is the registered cell_solution of this cycle.
   always_comb begin
      mask_d   = mask_q;
      col_d    = col_q;
      err_d    = err_q;
      mask_new = mask_q;
      if (start_acc) begin
         mask_d = '0;
         col_d  = '0;
         err_d  = 1'b0;
      end else if (accept) begin
         if (sol_q != '0 && sol_q <= DIGIT_W'(9)) begin
            mask_new = mask_q | (9'b1 << (sol_q - DIGIT_W'(1)));
         end else begin
            err_d = 1'b1;
         end
         if (col_q == 4'd8) begin
            if (mask_new != 9'h1FF) begin
               err_d = 1'b1;
            end
            mask_d = '0;
            col_d  = '0;
         end else begin
            mask_d = mask_new;
            col_d  = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask_q <= '0;
         col_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         mask_q <= mask_d;
         col_q  <= col_d;
         err_q  <= err_d;
      end
   end

   assign map_err_o = err_q;
`else
   assign map_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_map_loader.sv
`timescale 1ns/1ps
module tb_map_loader;
   localparam int NM  = 15;
   localparam int NC  = 81;
   localparam int DW  = 4;
   localparam int TOT = NM * NC;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [3:0]      sel = '0;
   logic [TOT*DW-1:0] maps;
   logic [TOT-1:0]  vis_bus;
   logic            busy, done, sel_err, map_err;

   map_loader_if #(.AW(7), .DW(4)) cif ();

   map_loader #(.NUM_MAPS(NM), .CELLS(NC), .DIGIT_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .puzzle_sel_i(sel),
      .maps_i(maps), .visibilities_i(vis_bus),
      .busy_o(busy), .done_o(done), .sel_err_o(sel_err), .map_err_o(map_err),
      .cell_if(cif)
   );

   always #5 clk = ~clk;

   // ---------------- puzzle bank contents ----------------
   int dig [NM][NC];
   bit vis [NM][NC];
   int checks = 0;
   int failures = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Latin-square construction that yields valid sudoku solutions; puzzle 0
   // row 0 comes out as 8,1,2,6,7,4,5,3,9.
   task automatic build_bank();
      int perm [9] = '{8, 1, 2, 6, 7, 4, 5, 3, 9};
      for (int p = 0; p < NM; p++)
         for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
               dig[p][r*9+c] = perm[((r*3 + r/3 + c) + p) % 9];
               vis[p][r*9+c] = ((r*5 + c*3 + p*7) % 7) < 3;
            end
   endtask

   task automatic pack_bank();
      for (int p = 0; p < NM; p++)
         for (int c = 0; c < NC; c++) begin
            maps[TOT*DW-1-DW*(p*NC+c) -: DW] = 4'(dig[p][c]);
            vis_bus[TOT-1-(p*NC+c)]          = vis[p][c];
         end
   endtask

   // Index of the accept after which the row check must have flagged map p.
   function automatic int err_point(int p);
      for (int r = 0; r < 9; r++) begin
         int m = 0;
         for (int c = 0; c < 9; c++) begin
            int d = dig[p][r*9+c];
            if (d < 1 || d > 9) return r*9+c;
            m = m | (1 << (d-1));
         end
         if (m != 511) return r*9+8;
      end
      return 999;
   endfunction

   // ---------------- behavioural model + compare ----------------
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int m_phase = 0;       // 0 idle, 1 streaming, 2 done cycle
   int m_sel = 0, m_idx = 0, m_acc = 0, m_err_at = 999;
   bit m_done = 0, m_selerr = 0;
   int start_cyc = 0, first_valid_cyc = -1, done_cyc = -1;
   int acc_count = 0, selerr_cnt = 0;
   int cap [NC];
   logic [6:0] prev_addr;
   logic [3:0] prev_sol;
   bit prev_stall = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs", 32'({busy, done, sel_err, map_err, cif.cell_valid, cif.cell_addr,
                                   cif.cell_value, cif.cell_solution, cif.cell_given}), 32'd0);
         m_phase = 0; m_done = 0; m_selerr = 0; m_acc = 0; m_err_at = 999; prev_stall = 0;
      end else begin
         int ed;
         chk("cell_valid", 32'(cif.cell_valid), 32'(m_phase == 1));
         chk("busy", 32'(busy), 32'(m_phase == 1));
         chk("done", 32'(done), 32'(m_done));
         chk("sel_err", 32'(sel_err), 32'(m_selerr));
`ifdef MAP_LOADER_CHECK_EN
         chk("map_err", 32'(map_err), 32'(m_acc > m_err_at));
`else
         chk("map_err", 32'(map_err), 32'd0);
`endif
         if (m_phase == 1) begin
            ed = dig[m_sel][m_idx];
            chk("cell_addr", 32'(cif.cell_addr), 32'(m_idx));
            chk("cell_solution", 32'(cif.cell_solution), 32'(ed));
            chk("cell_given", 32'(cif.cell_given), 32'(vis[m_sel][m_idx]));
            chk("cell_value", 32'(cif.cell_value), vis[m_sel][m_idx] ? 32'(ed) : 32'd0);
         end
         if (prev_stall) begin
            chk("hold_addr", 32'(cif.cell_addr), 32'(prev_addr));
            chk("hold_solution", 32'(cif.cell_solution), 32'(prev_sol));
         end
         prev_stall = cif.cell_valid && !cif.cell_ready;
         prev_addr  = cif.cell_addr;
         prev_sol   = cif.cell_solution;
         if (sel_err) selerr_cnt++;
         if (cif.cell_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (cif.cell_valid && cif.cell_ready) begin
            cap[cif.cell_addr] = int'(cif.cell_solution);
            acc_count++;
         end
         if (done) begin
            done_cyc = cyc;
            $display("LOAD done sel=%0d accepts=%0d cycle=%0d map_err=%0d", m_sel, acc_count, cyc, map_err);
         end
         // advance model to the next cycle
         m_done = 0; m_selerr = 0;
         case (m_phase)
            0: if (start) begin
                  if (int'(sel) < NM) begin
                     m_phase = 1; m_sel = int'(sel); m_idx = 0; m_acc = 0;
                     m_err_at = err_point(int'(sel));
                  end else m_selerr = 1;
               end
            1: if (cif.cell_ready) begin
                  m_acc++;
                  if (m_idx == NC-1) begin m_phase = 2; m_done = 1; end
                  else m_idx++;
               end
            default: m_phase = 0;
         endcase
      end
   end

   // ---------------- ready driver ----------------
   int rdy_mode = 0;   // 0: always ready, 1: random with a stall at addr 40
   int stall = 0;
   initial begin
      cif.cell_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (rdy_mode == 1) begin
            if (cif.cell_valid && cif.cell_addr == 7'd40 && stall < 5) begin
               cif.cell_ready = 1'b0;
               stall++;
            end else begin
               cif.cell_ready = 1'($urandom_range(0, 1));
            end
         end else begin
            cif.cell_ready = 1'b1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_start(int s);
      start = 1'b1; sel = 4'(s);
      start_cyc = cyc; first_valid_cyc = -1; done_cyc = -1; acc_count = 0;
      $display("START sel=%0d cycle=%0d", s, cyc);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(string nm, int limit);
      bit seen = 0;
      int n = 0;
      while (n < limit && !seen) begin
         @(negedge clk);
         if (done) seen = 1;
         n++;
      end
      chk({nm, "_done_seen"}, 32'(seen), 32'd1);
      tick();
   endtask

   task automatic wait_addr(int a, int limit);
      bit seen = 0;
      int n = 0;
      while (n < limit && !seen) begin
         tick();
         if (cif.cell_valid && int'(cif.cell_addr) == a) seen = 1;
         n++;
      end
      chk("addr_reached", 32'(seen), 32'd1);
   endtask

   initial begin
      int row0 [9] = '{8, 1, 2, 6, 7, 4, 5, 3, 9};
      build_bank();
      pack_bank();
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // 1: basic load of puzzle 0 with latency
      do_start(0);
      wait_done("t1", 200);
      chk("t1_first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd1);
      chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd82);
      chk("t1_accepts", 32'(acc_count), 32'd81);
      for (int c = 0; c < 9; c++) chk("t1_row0_solution", 32'(cap[c]), 32'(row0[c]));
      chk("t1_busy_after", 32'(busy), 32'd0);

      // 2: every puzzle
      for (int s = 0; s < NM; s++) begin
         do_start(s);
         wait_done("t2", 200);
         chk("t2_accepts", 32'(acc_count), 32'd81);
      end

      // 3: random backpressure with a 5-cycle stall at addr 40
      rdy_mode = 1; stall = 0;
      do_start(9);
      wait_done("t3", 3000);
      rdy_mode = 0;
      chk("t3_accepts", 32'(acc_count), 32'd81);
      chk("t3_stall_cycles", 32'(stall), 32'd5);
      tick();

      // 4: out-of-range select, then start while busy
      selerr_cnt = 0;
      do_start(15);
      repeat (3) tick();
      chk("t4_sel_err_pulses", 32'(selerr_cnt), 32'd1);
      chk("t4_busy_idle", 32'(busy), 32'd0);
      do_start(5);
      wait_addr(20, 100);
      start = 1'b1; sel = 4'd1;
      tick();
      start = 1'b0;
      wait_done("t4", 200);
      chk("t4_accepts", 32'(acc_count), 32'd81);

      // 5: reset mid-load
      do_start(7);
      wait_addr(37, 100);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(cif.cell_valid), 32'd0);
      chk("t5_async_addr", 32'(cif.cell_addr), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      done_cyc = -1;
      repeat (3) tick();
      chk("t5_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
      do_start(3);
      wait_done("t5", 200);
      chk("t5_accepts", 32'(acc_count), 32'd81);

`ifdef MAP_LOADER_CHECK_EN
      // 6: duplicate digit in row 4 of puzzle 2
      begin
         int saved = dig[2][4*9+3];
         dig[2][4*9+3] = dig[2][4*9+2];
         pack_bank();
         chk("t6_model_err_point", 32'(err_point(2)), 32'd44);
         do_start(2);
         wait_done("t6", 200);
         chk("t6_map_err_held", 32'(map_err), 32'd1);
         dig[2][4*9+3] = saved;
         pack_bank();
         do_start(2);
         wait_done("t6b", 200);
         chk("t6_map_err_clean", 32'(map_err), 32'd0);
      end
`endif

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
